// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the memory-mapped countdown timer.
//   - register word offsets (addr[3:2] of the byte address)
//   - CTRL bit positions and MODE encodings
//   - FSM state encoding
package timer_pkg;

  // Register word offsets
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE encodings (10/11 fall back to one-shot behaviour)
  localparam logic [1:0] MODE_ONESHOT    = 2'b00;
  localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock into one-cycle count ticks.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the division (counter back to 0)
//   enable     : advance the divider this cycle
//   tick       : high for the enabled cycle that completes PRESCALE cycles
// PRESCALE=1 gives a tick on every enabled cycle.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_reg;

  assign tick = enable && (presc_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc_reg <= '0;
    end else if (enable) begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// timer_counter: programmable countdown timer on the CPU peripheral bus.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears all state)
//   addr       : word offset (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
//   we         : write strobe, sampled on rising clk
//   wdata      : write data
//   rdata      : combinational read data for addr
//   irq        : interrupt request (flag gated by CTRL.IM)
// Modes: one-shot stops on expiry with a sticky flag; auto-reload
// reloads from PRESET and produces a single-cycle irq pulse.
module timer_counter
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t           state_reg, state_next;
  logic [3:0]       ctrl_reg, ctrl_next;
  logic [CNT_W-1:0] preset_reg, preset_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             irq_flag_reg, irq_flag_next;

  logic presc_clear;
  logic presc_en;
  logic tick;
  logic auto_mode;

  assign auto_mode   = (ctrl_reg[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTORELOAD);
  assign presc_clear = (state_reg == LOAD);
  assign presc_en    = (state_reg == CNT) && ctrl_reg[CTRL_EN];

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .enable(presc_en),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ctrl_reg     <= '0;
      preset_reg   <= '0;
      count_reg    <= '0;
      irq_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      preset_reg   <= preset_next;
      count_reg    <= count_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ctrl_next     = ctrl_reg;
    preset_next   = preset_reg;
    count_next    = count_reg;
    irq_flag_next = irq_flag_reg;

    case (state_reg)
      IDLE: begin
        if (ctrl_reg[CTRL_EN]) state_next = LOAD;
      end
      LOAD: begin
        if (ctrl_reg[CTRL_EN]) begin
          count_next = preset_reg;
          state_next = CNT;
        end else begin
          state_next = IDLE;
        end
      end
      CNT: begin
        if (!ctrl_reg[CTRL_EN]) begin
          state_next = IDLE;
        end else if (tick) begin
          // Expiry is detected one tick after reaching zero, so count
          // never wraps below zero.
          if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
          end else begin
            state_next    = INT;
            irq_flag_next = 1'b1;
          end
        end
      end
      INT: begin
        if (auto_mode) begin
          irq_flag_next = 1'b0;
          state_next    = LOAD;
        end else begin
          ctrl_next[CTRL_EN] = 1'b0;
          state_next         = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // CPU writes override FSM updates on the same edge.
    if (we) begin
      case (addr)
        REG_CTRL: begin
          ctrl_next     = wdata[3:0];
          irq_flag_next = 1'b0;
        end
        REG_PRESET: preset_next = CNT_W'(wdata);
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL:   rdata = {28'b0, ctrl_reg};
      REG_PRESET: rdata = 32'(preset_reg);
      REG_COUNT:  rdata = 32'(count_reg);
      default:    rdata = '0;
    endcase
  end

  assign irq = irq_flag_reg & ctrl_reg[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: constant-expectation vector table,
// directed corner sequences, and randomized traffic checked against a
// timestamp-based reference model (expiry edge = load edge + (N+1)*P).
module tb_timer_counter;

  localparam int MP = 1;  // prescale of the modelled DUT

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata4;
  logic        irq, irq4;

  always #5 clk = ~clk;

  timer_counter #(.PRESCALE(MP), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  timer_counter #(.PRESCALE(4), .CNT_W(32)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata4), .irq(irq4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_preset = '0;
  logic [31:0] m_count = '0;
  bit          m_flag = 1'b0;
  bit          m_busy = 1'b0;
  longint      m_load_at = 0, m_expire_at = 0, m_n = 0, k = 0;

  task automatic model_step(input bit r, input bit w, input bit [1:0] a, input logic [31:0] d);
    bit en;
    bit auto_mode;
    k++;
    en        = m_ctrl[0];
    auto_mode = (m_ctrl[2:1] == 2'b01);
    if (r) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_busy = 1'b0;
      return;
    end
    if (!m_busy) begin
      if (en) begin
        m_busy    = 1'b1;
        m_load_at = k + 1;
      end
    end else if (k == m_load_at) begin
      if (en) begin
        m_n         = longint'(m_preset);
        m_count     = m_preset;
        m_expire_at = k + (m_n + 1) * MP;
      end else begin
        m_busy = 1'b0;
      end
    end else if (k <= m_expire_at) begin
      if (!en) m_busy = 1'b0;
      else if (k == m_expire_at) m_flag = 1'b1;
      else m_count = 32'(m_n - (k - m_load_at) / MP);
    end else begin
      if (auto_mode) begin
        m_flag    = 1'b0;
        m_load_at = k + 1;
      end else begin
        m_ctrl[0] = 1'b0;
        m_busy    = 1'b0;
      end
    end
    if (w && a == 2'd0) begin
      m_ctrl = d[3:0];
      m_flag = 1'b0;
    end else if (w && a == 2'd1) begin
      m_preset = d;
    end
  endtask

  function automatic logic [31:0] mread(input bit [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic read_at(input bit [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // One bus transaction: drive, clock, then compare every register and irq.
  task automatic cyc(input bit r, input bit w, input bit [1:0] a, input logic [31:0] d);
    logic [31:0] v;
    reset = r; we = w; addr = a; wdata = d;
    model_step(r, w, a, d);
    @(posedge clk);
    #1;
    cmp("irq_model", {31'b0, irq}, {31'b0, m_flag & m_ctrl[3]});
    for (int i = 0; i < 4; i++) begin
      read_at(i[1:0], v);
      cmp($sformatf("rd%0d_model", i), v, mread(i[1:0]));
    end
    $display("txn edge=%0d rst=%0b we=%0b addr=%0d wdata=%h irq=%0b count=%0d",
             k, r, w, a, d, irq, m_count);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          we;
    bit [1:0]    addr;
    logic [31:0] wdata;
    bit [1:0]    chk_addr;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit w, input bit [1:0] a, input logic [31:0] d,
                     input bit [1:0] ca, input logic [31:0] er, input bit ei);
    vec_t t;
    t.rst = r; t.we = w; t.addr = a; t.wdata = d;
    t.chk_addr = ca; t.exp_rd = er; t.exp_irq = ei;
    vecs.push_back(t);
  endtask

  initial begin
    logic [31:0] rv;
    bit          r, w;
    bit [1:0]    a;
    logic [31:0] d;

    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;

    // One-shot, PRESET=5, CTRL=0x9 at E0
    add(1, 0, 0, 0,      2, 0, 0);   // reset: count 0
    add(0, 1, 1, 5,      1, 5, 0);   // PRESET=5
    add(0, 1, 0, 32'h9,  0, 9, 0);   // E0
    add(0, 0, 0, 0,      2, 0, 0);   // E1 LOAD
    add(0, 0, 0, 0,      2, 5, 0);   // E2
    add(0, 0, 0, 0,      2, 4, 0);   // E3
    add(0, 0, 0, 0,      2, 3, 0);
    add(0, 0, 0, 0,      2, 2, 0);
    add(0, 0, 0, 0,      2, 1, 0);
    add(0, 0, 0, 0,      2, 0, 0);   // E7
    add(0, 0, 0, 0,      0, 9, 1);   // E8 INT, irq high
    add(0, 0, 0, 0,      0, 8, 1);   // E9 EN cleared, irq sticky
    add(0, 0, 0, 0,      2, 0, 1);
    add(0, 1, 0, 32'h8,  0, 8, 0);   // CTRL write clears flag
    // Auto-reload, PRESET=3, CTRL=0xB
    add(1, 0, 0, 0,      0, 0, 0);
    add(0, 1, 1, 3,      1, 3, 0);
    add(0, 1, 0, 32'hB,  0, 32'hB, 0); // E0
    add(0, 0, 0, 0,      2, 0, 0);   // E1
    add(0, 0, 0, 0,      2, 3, 0);   // E2
    add(0, 0, 0, 0,      2, 2, 0);
    add(0, 0, 0, 0,      2, 1, 0);
    add(0, 0, 0, 0,      2, 0, 0);   // E5
    add(0, 0, 0, 0,      2, 0, 1);   // E6 pulse
    add(0, 0, 0, 0,      2, 0, 0);   // E7 LOAD
    add(0, 0, 0, 0,      2, 3, 0);   // E8 reloaded
    add(0, 0, 0, 0,      2, 2, 0);
    add(0, 0, 0, 0,      2, 1, 0);
    add(0, 0, 0, 0,      2, 0, 0);
    add(0, 0, 0, 0,      0, 32'hB, 1); // E12 pulse
    add(0, 0, 0, 0,      0, 32'hB, 0); // E13
    add(0, 1, 0, 32'hFFFF_FFF0, 0, 0, 0); // upper bits ignored

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      read_at(vecs[i].chk_addr, rv);
      cmp($sformatf("vec%0d_rd", i), rv, vecs[i].exp_rd);
      cmp($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // PRESET=0: irq high after E3
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 32'h9);
    for (int e = 1; e <= 4; e++) begin
      idle();
      cmp($sformatf("preset0_irq_E%0d", e), {31'b0, irq}, {31'b0, (e >= 3)});
    end

    // Disable mid-count freezes; re-enable restarts from PRESET
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 12);
    cyc(0, 1, 0, 32'h9);
    for (int e = 1; e <= 4; e++) idle();
    read_at(2, rv); cmp("freeze_pre", rv, 10);
    cyc(0, 1, 0, 32'h0);
    for (int e = 0; e < 3; e++) idle();
    read_at(2, rv); cmp("freeze_hold", rv, 9);
    cyc(0, 1, 0, 32'h9);
    idle(); idle();
    read_at(2, rv); cmp("restart_preset", rv, 12);

    // IM=0: flag set but irq stays low; CTRL write with IM=1 clears flag
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 2);
    cyc(0, 1, 0, 32'h1);
    for (int e = 1; e <= 6; e++) begin
      idle();
      cmp($sformatf("im0_irq_E%0d", e), {31'b0, irq}, 32'd0);
    end
    cyc(0, 1, 0, 32'h8);
    cmp("im_set_irq", {31'b0, irq}, 32'd0);

    // reset mid-count wins over a simultaneous write
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 9);
    cyc(0, 1, 0, 32'h9);
    for (int e = 0; e < 4; e++) idle();
    cyc(1, 1, 1, 32'h55);
    for (int i = 0; i < 3; i++) begin
      read_at(i[1:0], rv);
      cmp($sformatf("rst_mid_rd%0d", i), rv, 0);
    end
    cmp("rst_mid_irq", {31'b0, irq}, 32'd0);

    // Writes to COUNT/reserved ignored; PRESET mid-count doesn't move expiry
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 4);
    cyc(0, 1, 0, 32'h9);                 // E0
    idle(); idle();                      // E1, E2
    cyc(0, 1, 2, 32'hFFFF_FFFF);         // E3
    cyc(0, 1, 3, 32'hFFFF_FFFF);         // E4
    read_at(3, rv); cmp("addr3_zero", rv, 0);
    read_at(2, rv); cmp("count_unaffected", rv, 2);
    cyc(0, 1, 1, 20);                    // E5
    idle();                              // E6
    cmp("preset_mid_E6", {31'b0, irq}, 32'd0);
    idle();                              // E7
    cmp("preset_mid_E7", {31'b0, irq}, 32'd1);

    // PRESCALE=4 instance, PRESET=2: irq high after E14
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 2);
    cyc(0, 1, 0, 32'h9);
    for (int e = 1; e <= 16; e++) begin
      idle();
      cmp($sformatf("p4_irq_E%0d", e), {31'b0, irq4}, {31'b0, (e >= 14)});
      if (e == 2 || e == 6 || e == 13) begin
        addr = 2'd2;
        #1;
        cmp($sformatf("p4_count_E%0d", e), rdata4, (e == 2) ? 2 : (e == 6) ? 1 : 0);
      end
    end

    // Randomized traffic against the model
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = 32'($urandom_range(0, 6));
      if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
      cyc(r, w, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
